otter_int_csr: RTL and testbench
================================

Name: otter_int_csr

Overview:
- Machine-mode CSR file and interrupt front end for the multicycle OTTER core.
- Synchronises the external interrupt line and produces the CU's interrupt request inputs.
- Responds to the CU outputs intTaken, csrWrite and intCLR, plus an MRET pulse.
- Supplies the trap vector and saved PC to the PC mux.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- SYNC_STAGES, 2, flip-flop depth of the external-interrupt synchroniser (minimum 2).

Ports:
- CSR_CLK  in  1  core clock.
- CSR_RESET  in  1  asynchronous, active-high reset.
- CSR_INT_IN  in  1  raw external interrupt level, asynchronous to CSR_CLK.
- CSR_intTaken  in  1  CU is in its interrupt-entry cycle.
- CSR_intCLR  in  1  CU is in the last cycle of an instruction, or in the interrupt cycle.
- CSR_csrWrite  in  1  CSRRW executing this cycle.
- CSR_MRET  in  1  MRET executing this cycle; one-cycle pulse qualified by EXECUTE.
- CSR_ADDR  in  12  CSR address (instruction bits [31:20]).
- CSR_WD  in  32  CSR write data (rs1).
- CSR_PC  in  32  address of the next instruction to execute.
- CSR_INT  out  1  interrupt request pulse, to CU_INT.
- CSR_prevINT  out  1  latched pending request, to CU_prevINT.
- CSR_RD  out  32  CSR read data (old value).
- CSR_MTVEC  out  32  trap vector.
- CSR_MEPC  out  32  saved return PC.

Behaviour:
- Reset (async, immediate):
  - sync chain, edge register and prev latch = 0.
  - mstatus, mie, mepc, mcause = 0; mtvec = MTVEC_RESET.
  - All outputs therefore read 0, except CSR_MTVEC = MTVEC_RESET.
- Synchroniser: SYNC_STAGES flops, then one delay flop.
  - rise = sync_out & ~sync_dly.
  - Latency: CSR_INT_IN rising to rise = SYNC_STAGES+1 clock edges.
- Enable: en = mstatus.MIE (bit 3) & mie.MEIE (bit 11).
- CSR_INT = rise & en. Combinational from registers, high for exactly one cycle.
- CSR_prevINT register: next = CSR_intCLR ? 0 : (CSR_prevINT | CSR_INT).
  - Holds a request seen mid-instruction until the CU samples it at instruction end.
  - When CSR_INT and CSR_intCLR coincide, the CU consumes CSR_INT directly and prev stays 0.
- Edges are not queued:
  - A rise while en=0 is discarded.
  - A rise during the CSR_intTaken cycle is discarded.
- Interrupt entry (CSR_intTaken=1), on that clock:
  - mepc <= {CSR_PC[31:2], 2'b00}.
  - mcause <= 32'h8000_000B.
  - MPIE <= MIE; MIE <= 0.
- MRET (CSR_MRET=1): MIE <= MPIE; MPIE <= 1.
- CSRRW (CSR_csrWrite=1), by address:
  - 0x300 mstatus: only bits 3 and 7 writable; other bits read 0.
  - 0x304 mie: only bit 11 writable.
  - 0x305 mtvec: bits [1:0] forced 0.
  - 0x341 mepc: bits [1:0] forced 0.
  - 0x342 mcause: full 32 bits.
  - 0x344 mip: read-only; bit 11 = sync_out.
  - Any other address: write ignored, reads 0.
- CSR_RD: combinational read of CSR_ADDR, giving the pre-write value, so CSRRW returns the old CSR.
- Priority when strobes coincide: intTaken > MRET > csrWrite. The lower-priority update is dropped entirely.
- CSR_MTVEC and CSR_MEPC drive the registers directly (0 cycles).
- Reset mid-handler: all state returns to reset values and pending edges are lost.

Decomposition:
- Package otter_csr_pkg:
  - CSR address localparams (MSTATUS, MIE, MTVEC, MEPC, MCAUSE, MIP).
  - Bit indices MSTATUS_MIE=3, MSTATUS_MPIE=7, MEIE=11.
  - MCAUSE_EXT_INT = 32'h8000_000B.
- One sub-module: otter_sync_edge, the SYNC_STAGES synchroniser plus rising-edge detector, with outputs level and rise.

Test Plan:
- Reset: assert CSR_RESET mid-clock -> all CSRs 0, CSR_MTVEC=MTVEC_RESET, CSR_INT=CSR_prevINT=0 without waiting for a clock edge.
- Enable path:
  - Stimulus: CSRRW 0x304 WD=32'h800, then CSRRW 0x300 WD=32'h8, then raise CSR_INT_IN.
  - Required: CSR_INT pulses 1 cycle exactly 3 edges later; CSR_prevINT rises the next cycle and stays high until CSR_intCLR.
- Masked edge: MIE=0, raise CSR_INT_IN -> no CSR_INT, no prevINT; mip reads 32'h800. Then set MIE=1 with the line still high -> still no request (level is not an edge).
- Entry and return:
  - Stimulus: intTaken with CSR_PC=32'h0000_0104, MIE=1.
  - Required after entry: mepc=32'h104, mcause=32'h8000_000B, mstatus=32'h80.
  - Required after a following MRET: mstatus=32'h88.
- CSRRW read/write:
  - Stimulus: ADDR=0x305, WD=32'h0000_2003.
  - Required: CSR_RD shows the old mtvec during the write cycle; after the write CSR_MTVEC=32'h0000_2000.
  - Stimulus: write to 0x344 or 0x123 -> no state change; read of 0x123 returns 0.
- Collisions:
  - intTaken with csrWrite to mepc -> mepc=CSR_PC.
  - CSR_INT coincident with intCLR -> prevINT stays 0.
  - Edge during the intTaken cycle -> dropped.

Source files
------------

// File: rtl/otter_csr_pkg.sv
// Shared CSR addresses, bit positions and trap cause for the OTTER CSR file.
package otter_csr_pkg;

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MIP     = 12'h344;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MEIE         = 11;

   localparam logic [31:0] MCAUSE_EXT_INT = 32'h8000_000B;

   // Build the architectural mstatus view from the two implemented bits.
   function automatic logic [31:0] pack_mstatus(input logic mie, input logic mpie);
      logic [31:0] v;
      v = 32'h0;
      v[MSTATUS_MIE]  = mie;
      v[MSTATUS_MPIE] = mpie;
      return v;
   endfunction

endpackage

// File: rtl/otter_sync_edge.sv
// External interrupt synchroniser followed by a registered rising-edge detector.
// rise is high for one cycle, SYNC_STAGES+1 clock edges after din goes high.
module otter_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              dly_q;
   logic              rise_q;

   assign level = sync_q[STAGES-1];
   assign rise  = rise_q;

   // Synchroniser chain, delay flop and registered edge pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         dly_q  <= level;
         rise_q <= level & ~dly_q;
      end
   end

endmodule

// File: rtl/otter_int_csr.sv
// Machine-mode CSR file and interrupt front end for the multicycle OTTER core.
module otter_int_csr
   import otter_csr_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        CSR_CLK,
   input  logic        CSR_RESET,
   input  logic        CSR_INT_IN,
   input  logic        CSR_intTaken,
   input  logic        CSR_intCLR,
   input  logic        CSR_csrWrite,
   input  logic        CSR_MRET,
   input  logic [11:0] CSR_ADDR,
   input  logic [31:0] CSR_WD,
   input  logic [31:0] CSR_PC,
   output logic        CSR_INT,
   output logic        CSR_prevINT,
   output logic [31:0] CSR_RD,
   output logic [31:0] CSR_MTVEC,
   output logic [31:0] CSR_MEPC
);

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   logic        level;
   logic        rise;
   logic        mie_bit;
   logic        mpie_bit;
   logic        meie_bit;
   logic [31:0] mtvec_q;
   logic [31:0] mepc_q;
   logic [31:0] mcause_q;
   logic        prev_q;
   logic [31:0] rd;

   otter_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (CSR_CLK),
      .rst   (CSR_RESET),
      .din   (CSR_INT_IN),
      .level (level),
      .rise  (rise)
   );

   assign CSR_INT     = rise & mie_bit & meie_bit;
   assign CSR_prevINT = prev_q;
   assign CSR_MTVEC   = mtvec_q;
   assign CSR_MEPC    = mepc_q;
   assign CSR_RD      = rd;

   // Pending-request latch; a request in the entry cycle is dropped, not held.
   always_ff @(posedge CSR_CLK or posedge CSR_RESET) begin
      if (CSR_RESET)
         prev_q <= 1'b0;
      else if (CSR_intCLR || CSR_intTaken)
         prev_q <= 1'b0;
      else
         prev_q <= prev_q | CSR_INT;
   end

   // CSR state updates: interrupt entry beats MRET beats CSRRW.
   always_ff @(posedge CSR_CLK or posedge CSR_RESET) begin
      if (CSR_RESET) begin
         mie_bit  <= 1'b0;
         mpie_bit <= 1'b0;
         meie_bit <= 1'b0;
         mtvec_q  <= MTVEC_RESET;
         mepc_q   <= 32'h0;
         mcause_q <= 32'h0;
      end else if (CSR_intTaken) begin
         mepc_q   <= CSR_PC & ALIGN_MASK;
         mcause_q <= MCAUSE_EXT_INT;
         mpie_bit <= mie_bit;
         mie_bit  <= 1'b0;
      end else if (CSR_MRET) begin
         mie_bit  <= mpie_bit;
         mpie_bit <= 1'b1;
      end else if (CSR_csrWrite) begin
         case (CSR_ADDR)
            ADDR_MSTATUS: begin
               mie_bit  <= CSR_WD[MSTATUS_MIE];
               mpie_bit <= CSR_WD[MSTATUS_MPIE];
            end
            ADDR_MIE:    meie_bit <= CSR_WD[MEIE];
            ADDR_MTVEC:  mtvec_q  <= CSR_WD & ALIGN_MASK;
            ADDR_MEPC:   mepc_q   <= CSR_WD & ALIGN_MASK;
            ADDR_MCAUSE: mcause_q <= CSR_WD;
            default: ;
         endcase
      end
   end

   // Read mux returns the current (pre-write) contents of the addressed CSR.
   always_comb begin
      rd = 32'h0;
      case (CSR_ADDR)
         ADDR_MSTATUS: rd = pack_mstatus(mie_bit, mpie_bit);
         ADDR_MIE:     rd[MEIE] = meie_bit;
         ADDR_MTVEC:   rd = mtvec_q;
         ADDR_MEPC:    rd = mepc_q;
         ADDR_MCAUSE:  rd = mcause_q;
         ADDR_MIP:     rd[MEIE] = level;
         default:      rd = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_otter_int_csr.sv
// Directed bench for otter_int_csr with hand-computed expectations.
module tb_otter_int_csr;

   localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        int_in = 1'b0;
   logic        int_taken = 1'b0;
   logic        int_clr = 1'b0;
   logic        csr_write = 1'b0;
   logic        mret = 1'b0;
   logic [11:0] addr = 12'h0;
   logic [31:0] wd = 32'h0;
   logic [31:0] pc = 32'h0;
   logic        csr_int;
   logic        prev_int;
   logic [31:0] rd;
   logic [31:0] mtvec;
   logic [31:0] mepc;

   int n_checks = 0;
   int n_fail   = 0;

   otter_int_csr #(.MTVEC_RESET(MTVEC_RST), .SYNC_STAGES(2)) dut (
      .CSR_CLK      (clk),
      .CSR_RESET    (rst),
      .CSR_INT_IN   (int_in),
      .CSR_intTaken (int_taken),
      .CSR_intCLR   (int_clr),
      .CSR_csrWrite (csr_write),
      .CSR_MRET     (mret),
      .CSR_ADDR     (addr),
      .CSR_WD       (wd),
      .CSR_PC       (pc),
      .CSR_INT      (csr_int),
      .CSR_prevINT  (prev_int),
      .CSR_RD       (rd),
      .CSR_MTVEC    (mtvec),
      .CSR_MEPC     (mepc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rd, exp);
   endtask

   task automatic csr_wr(input string tag, input logic [11:0] a, input logic [31:0] d,
                         input logic [31:0] exp_old);
      addr = a;
      wd = d;
      csr_write = 1'b1;
      #1;
      check(tag, rd, exp_old);
      tick();
      csr_write = 1'b0;
   endtask

   task automatic settle_low();
      int_in = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      // power-on reset
      repeat (3) tick();
      check("por_int", {31'h0, csr_int}, 32'h0);
      check("por_prev", {31'h0, prev_int}, 32'h0);
      check("por_mtvec", mtvec, MTVEC_RST);
      check("por_mepc", mepc, 32'h0);
      rd_check("por_mstatus", 12'h300, 32'h0);
      rst = 1'b0;
      tick();

      // enable path
      csr_wr("wr_mie_old", 12'h304, 32'h800, 32'h0);
      csr_wr("wr_mstatus_old", 12'h300, 32'h8, 32'h0);
      rd_check("mie_rd", 12'h304, 32'h800);
      int_in = 1'b1;
      tick(); check("en_e1_int", {31'h0, csr_int}, 32'h0);
      tick(); check("en_e2_int", {31'h0, csr_int}, 32'h0);
      rd_check("en_mip", 12'h344, 32'h800);
      tick(); check("en_e3_int", {31'h0, csr_int}, 32'h1);
      check("en_e3_prev", {31'h0, prev_int}, 32'h0);
      tick(); check("en_e4_int", {31'h0, csr_int}, 32'h0);
      check("en_e4_prev", {31'h0, prev_int}, 32'h1);
      tick(); check("en_hold_prev", {31'h0, prev_int}, 32'h1);
      int_clr = 1'b1;
      tick(); int_clr = 1'b0;
      check("en_clr_prev", {31'h0, prev_int}, 32'h0);

      // masked edge, then enabling with the level still high
      settle_low();
      csr_wr("mask_mstatus_old", 12'h300, 32'h0, 32'h8);
      int_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mask_int", {31'h0, csr_int}, 32'h0);
      end
      check("mask_prev", {31'h0, prev_int}, 32'h0);
      rd_check("mask_mip", 12'h344, 32'h800);
      csr_wr("unmask_old", 12'h300, 32'h8, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("level_int", {31'h0, csr_int}, 32'h0);
      end
      check("level_prev", {31'h0, prev_int}, 32'h0);

      // interrupt entry and return
      pc = 32'h0000_0107;
      int_taken = 1'b1; int_clr = 1'b1;
      tick(); int_taken = 1'b0; int_clr = 1'b0;
      check("entry_mepc", mepc, 32'h104);
      rd_check("entry_mepc_rd", 12'h341, 32'h104);
      rd_check("entry_mcause", 12'h342, 32'h8000_000B);
      rd_check("entry_mstatus", 12'h300, 32'h80);
      mret = 1'b1;
      tick(); mret = 1'b0;
      rd_check("mret_mstatus", 12'h300, 32'h88);

      // CSRRW read-old / write-new
      csr_wr("mtvec_old", 12'h305, 32'h0000_2003, MTVEC_RST);
      check("mtvec_new", mtvec, 32'h0000_2000);
      csr_wr("mip_old", 12'h344, 32'hFFFF_FFFF, 32'h800);
      rd_check("mip_after_wr", 12'h344, 32'h800);
      csr_wr("bad_old", 12'h123, 32'hFFFF_FFFF, 32'h0);
      rd_check("bad_rd", 12'h123, 32'h0);
      rd_check("bad_mstatus", 12'h300, 32'h88);
      check("bad_mtvec", mtvec, 32'h0000_2000);
      check("bad_mepc", mepc, 32'h104);
      csr_wr("mstatus_ones_old", 12'h300, 32'hFFFF_FFFF, 32'h88);
      rd_check("mstatus_ones", 12'h300, 32'h88);
      csr_wr("mcause_old", 12'h342, 32'h1234_5678, 32'h8000_000B);
      rd_check("mcause_new", 12'h342, 32'h1234_5678);
      csr_wr("mepc_old", 12'h341, 32'h0000_3007, 32'h104);
      check("mepc_new", mepc, 32'h0000_3004);

      // intTaken beats csrWrite
      pc = 32'h0000_0200;
      addr = 12'h341; wd = 32'h0000_ABC0;
      csr_write = 1'b1; int_taken = 1'b1; int_clr = 1'b1;
      tick(); csr_write = 1'b0; int_taken = 1'b0; int_clr = 1'b0;
      check("col_mepc", mepc, 32'h200);
      rd_check("col_mcause", 12'h342, 32'h8000_000B);
      rd_check("col_mstatus", 12'h300, 32'h80);

      // MRET beats csrWrite
      addr = 12'h300; wd = 32'h0;
      csr_write = 1'b1; mret = 1'b1;
      tick(); csr_write = 1'b0; mret = 1'b0;
      rd_check("col_mret", 12'h300, 32'h88);

      // CSR_INT coincident with intCLR
      settle_low();
      int_in = 1'b1;
      repeat (3) tick();
      check("clr_int", {31'h0, csr_int}, 32'h1);
      int_clr = 1'b1;
      tick(); int_clr = 1'b0;
      check("clr_prev", {31'h0, prev_int}, 32'h0);
      tick();
      check("clr_prev2", {31'h0, prev_int}, 32'h0);

      // edge arriving in the intTaken cycle
      settle_low();
      int_in = 1'b1;
      repeat (3) tick();
      check("tk_int", {31'h0, csr_int}, 32'h1);
      int_taken = 1'b1; int_clr = 1'b1;
      tick(); int_taken = 1'b0; int_clr = 1'b0;
      check("tk_prev", {31'h0, prev_int}, 32'h0);
      rd_check("tk_mstatus", 12'h300, 32'h80);
      csr_wr("tk_reen_old", 12'h300, 32'h8, 32'h80);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("tk_lost_int", {31'h0, csr_int}, 32'h0);
         check("tk_lost_prev", {31'h0, prev_int}, 32'h0);
      end

      // pending request, then reset mid-handler
      settle_low();
      int_in = 1'b1;
      repeat (4) tick();
      check("pend_prev", {31'h0, prev_int}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_prev", {31'h0, prev_int}, 32'h0);
      check("rst_int", {31'h0, csr_int}, 32'h0);
      check("rst_mtvec", mtvec, MTVEC_RST);
      check("rst_mepc", mepc, 32'h0);
      rd_check("rst_mstatus", 12'h300, 32'h0);
      rd_check("rst_mie", 12'h304, 32'h0);
      rd_check("rst_mcause", 12'h342, 32'h0);
      rd_check("rst_mip", 12'h344, 32'h0);
      int_in = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check("post_rst_int", {31'h0, csr_int}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
